// File: rtl/sa_weight_addr_gen_if.sv
// rtl/sa_weight_addr_gen_if.sv - control and address handshake bundle for the weight address generator
interface sa_weight_addr_gen_if #(
    parameter int ADDR_W = 6
);
    logic              start;
    logic              clear;
    logic              transpose;
    logic [ADDR_W-1:0] base_addr;
    logic              ready;
    logic [ADDR_W-1:0] addr;
    logic              addr_valid;
    logic              busy;
    logic              done;

    modport master (
        input  start, clear, transpose, base_addr, ready,
        output addr, addr_valid, busy, done
    );

    modport slave (
        output start, clear, transpose, base_addr, ready,
        input  addr, addr_valid, busy, done
    );
endinterface

// File: rtl/sa_weight_addr_gen.sv
// rtl/sa_weight_addr_gen.sv - sweeps a ROWSxCOLS weight matrix in row- or column-major order
module sa_weight_addr_gen #(
    parameter int ROWS   = 3,
    parameter int COLS   = 3,
    parameter int ADDR_W = 6
) (
    input  logic                 clk,
    input  logic                 reset_n,
    sa_weight_addr_gen_if.master bus
);
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t            state, state_nxt;
    logic [RW-1:0]     r_cnt, r_nxt;
    logic [CW-1:0]     c_cnt, c_nxt;
    logic [ADDR_W-1:0] base_q, addr_q, offset_nxt;
    logic              trans_q;
    logic              fire, last;

    assign fire = (state == RUN) && bus.ready;
    assign last = (r_cnt == RW'(ROWS - 1)) && (c_cnt == CW'(COLS - 1));

    // Next element position; transpose selects which counter is the fast one.
    always_comb begin
        r_nxt = r_cnt;
        c_nxt = c_cnt;
        if (last) begin
            r_nxt = '0;
            c_nxt = '0;
        end else if (trans_q) begin
            if (r_cnt == RW'(ROWS - 1)) begin
                r_nxt = '0;
                c_nxt = c_cnt + CW'(1);
            end else begin
                r_nxt = r_cnt + RW'(1);
            end
        end else begin
            if (c_cnt == CW'(COLS - 1)) begin
                c_nxt = '0;
                r_nxt = r_cnt + RW'(1);
            end else begin
                c_nxt = c_cnt + CW'(1);
            end
        end
    end

    assign offset_nxt = ADDR_W'(r_nxt) * ADDR_W'(COLS) + ADDR_W'(c_nxt);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start) state_nxt = RUN;
            RUN:     if (fire && last) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (bus.clear) begin
            state_nxt = IDLE;
        end
    end

    always_comb begin
        bus.addr       = addr_q;
        bus.addr_valid = 1'b0;
        bus.busy       = 1'b0;
        bus.done       = 1'b0;
        case (state)
            RUN: begin
                bus.addr_valid = 1'b1;
                bus.busy       = 1'b1;
            end
            DONE:    bus.done = 1'b1;
            default: ;
        endcase
    end

    // addr is left untouched on the final acceptance so it holds its last value through IDLE.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt   <= '0;
            c_cnt   <= '0;
            base_q  <= '0;
            trans_q <= 1'b0;
            addr_q  <= '0;
        end else if (bus.clear) begin
            r_cnt <= '0;
            c_cnt <= '0;
        end else if (state == IDLE && bus.start) begin
            r_cnt   <= '0;
            c_cnt   <= '0;
            base_q  <= bus.base_addr;
            trans_q <= bus.transpose;
            addr_q  <= bus.base_addr;
        end else if (fire) begin
            r_cnt <= r_nxt;
            c_cnt <= c_nxt;
            if (!last) begin
                addr_q <= base_q + offset_nxt;
            end
        end
    end
endmodule

// File: tb/tb_sa_weight_addr_gen.sv
// tb/tb_sa_weight_addr_gen.sv - scoreboard bench for sa_weight_addr_gen
module tb_sa_weight_addr_gen;
    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    sa_weight_addr_gen_if #(.ADDR_W(6)) bus ();

    sa_weight_addr_gen #(.ROWS(3), .COLS(3), .ADDR_W(6)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;
    logic [5:0] exp_q[$];
    logic [5:0] obs_q[$];
    int n_done, n_valid, first_k, last_k, done_k;

    task automatic do_start(input logic [5:0] b, input logic tr);
        @(posedge clk); #1;
        bus.start = 1'b1; bus.base_addr = b; bus.transpose = tr;
        @(posedge clk); #1;
        bus.start = 1'b0; bus.base_addr = 6'h2a; bus.transpose = ~tr;
    endtask

    // Records every addr_valid cycle; ready is dropped on valid cycles stall_from..stall_from+stall_len-1.
    task automatic collect(input int stall_from, input int stall_len, input int max_cyc);
        obs_q.delete();
        n_done = 0; n_valid = 0; first_k = -1; last_k = -1; done_k = -1;
        for (int k = 0; k < max_cyc; k++) begin
            @(negedge clk);
            bus.ready = !(bus.addr_valid && (n_valid + 1) >= stall_from && (n_valid + 1) < stall_from + stall_len);
            if (bus.addr_valid) begin
                n_valid++;
                obs_q.push_back(bus.addr);
                if (first_k < 0) first_k = k;
                last_k = k;
            end
            if (bus.done) begin
                n_done++;
                done_k = k;
            end
        end
        bus.ready = 1'b1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        bus.start = 0; bus.clear = 0; bus.transpose = 0; bus.base_addr = 0; bus.ready = 1;
        #12;
        n_tests++; if (bus.addr !== 6'd0)      begin n_fail++; $display("FAIL reset_addr got %0d exp 0", bus.addr); end
        n_tests++; if (bus.addr_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b exp 0", bus.addr_valid); end
        n_tests++; if (bus.busy !== 1'b0)       begin n_fail++; $display("FAIL reset_busy got %b exp 0", bus.busy); end
        n_tests++; if (bus.done !== 1'b0)       begin n_fail++; $display("FAIL reset_done got %b exp 0", bus.done); end
        @(negedge clk); reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_transpose();
        int i;
        logic [5:0] o, e;
        int seq[9] = '{0, 3, 6, 1, 4, 7, 2, 5, 8};
        exp_q.delete();
        foreach (seq[j]) exp_q.push_back(6'(seq[j]));
        do_start(6'd0, 1'b1);
        collect(0, 0, 14);
        n_tests++; if (n_valid !== 9) begin n_fail++; $display("FAIL tr_count got %0d exp 9", n_valid); end
        i = 0;
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front();
            n_tests++; if (o !== e) begin n_fail++; $display("FAIL tr_addr[%0d] got %0d exp %0d", i, o, e); end
            i++;
        end
        n_tests++; if (first_k !== 0) begin n_fail++; $display("FAIL tr_latency got %0d exp 0", first_k); end
        n_tests++; if (n_done !== 1 || done_k !== last_k + 1) begin n_fail++; $display("FAIL tr_done got n=%0d k=%0d exp n=1 k=%0d", n_done, done_k, last_k + 1); end
        n_tests++; if (bus.busy !== 1'b0 || bus.addr_valid !== 1'b0) begin n_fail++; $display("FAIL tr_idle got busy=%b valid=%b exp 0 0", bus.busy, bus.addr_valid); end
    endtask

    task automatic test_row_major();
        int i;
        logic [5:0] o, e;
        exp_q.delete();
        for (int j = 0; j < 9; j++) exp_q.push_back(6'(j));
        do_start(6'd0, 1'b0);
        collect(0, 0, 14);
        n_tests++; if (n_valid !== 9) begin n_fail++; $display("FAIL rm_count got %0d exp 9", n_valid); end
        i = 0;
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front();
            n_tests++; if (o !== e) begin n_fail++; $display("FAIL rm_addr[%0d] got %0d exp %0d", i, o, e); end
            i++;
        end
        n_tests++; if (n_done !== 1 || done_k !== last_k + 1) begin n_fail++; $display("FAIL rm_done got n=%0d k=%0d exp n=1 k=%0d", n_done, done_k, last_k + 1); end
    endtask

    task automatic test_stall();
        int i;
        logic [5:0] o, e;
        int seq[11] = '{0, 3, 6, 6, 6, 1, 4, 7, 2, 5, 8};
        exp_q.delete();
        foreach (seq[j]) exp_q.push_back(6'(seq[j]));
        do_start(6'd0, 1'b1);
        collect(3, 2, 16);
        n_tests++; if (n_valid !== 11) begin n_fail++; $display("FAIL st_count got %0d exp 11", n_valid); end
        i = 0;
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front();
            n_tests++; if (o !== e) begin n_fail++; $display("FAIL st_addr[%0d] got %0d exp %0d", i, o, e); end
            i++;
        end
        n_tests++; if (n_done !== 1 || done_k !== 11) begin n_fail++; $display("FAIL st_done got n=%0d k=%0d exp n=1 k=11", n_done, done_k); end
    endtask

    task automatic test_wrap();
        int i;
        logic [5:0] o, e;
        exp_q.delete();
        for (int j = 0; j < 9; j++) exp_q.push_back(6'(60 + j));
        do_start(6'd60, 1'b0);
        collect(0, 0, 14);
        n_tests++; if (n_valid !== 9) begin n_fail++; $display("FAIL wr_count got %0d exp 9", n_valid); end
        i = 0;
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front();
            n_tests++; if (o !== e) begin n_fail++; $display("FAIL wr_addr[%0d] got %0d exp %0d", i, o, e); end
            i++;
        end
        n_tests++; if (bus.addr !== 6'd4) begin n_fail++; $display("FAIL wr_idle_hold got %0d exp 4", bus.addr); end
    endtask

    task automatic test_restart_clear();
        int nv, nd;
        logic [5:0] e;
        exp_q.delete();
        for (int j = 0; j < 6; j++) exp_q.push_back(6'(j));
        nv = 0; nd = 0;
        do_start(6'd0, 1'b0);
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            if (bus.addr_valid) begin
                nv++;
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 6'h3f;
                n_tests++; if (bus.addr !== e) begin n_fail++; $display("FAIL rc_addr[%0d] got %0d exp %0d", k, bus.addr, e); end
            end
            if (bus.done) nd++;
            bus.start     = (k == 4);
            bus.base_addr = (k == 4) ? 6'd10 : 6'd0;
            bus.clear     = (k == 6);
        end
        bus.clear = 1'b0;
        n_tests++; if (nv !== 6) begin n_fail++; $display("FAIL rc_count got %0d exp 6", nv); end
        n_tests++; if (nd !== 0) begin n_fail++; $display("FAIL rc_no_done got %0d exp 0", nd); end
        n_tests++; if (bus.busy !== 1'b0 || bus.addr_valid !== 1'b0) begin n_fail++; $display("FAIL rc_idle got busy=%b valid=%b exp 0 0", bus.busy, bus.addr_valid); end
    endtask

    task automatic test_reset_mid();
        int i;
        logic [5:0] o, e;
        logic bad;
        do_start(6'd5, 1'b0);
        repeat (3) @(negedge clk);
        #1 reset_n = 1'b0;
        #1;
        n_tests++; if ({bus.addr, bus.addr_valid, bus.busy, bus.done} !== 9'd0) begin n_fail++; $display("FAIL rm_async got addr=%0d v=%b b=%b d=%b exp all 0", bus.addr, bus.addr_valid, bus.busy, bus.done); end
        @(negedge clk); reset_n = 1'b1;
        bad = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (bus.addr_valid || bus.busy || bus.done) bad = 1'b1;
        end
        n_tests++; if (bad !== 1'b0) begin n_fail++; $display("FAIL rm_post_release got activity=%b exp 0", bad); end
        exp_q.delete();
        for (int j = 0; j < 9; j++) exp_q.push_back(6'(7 + j));
        do_start(6'd7, 1'b0);
        collect(0, 0, 12);
        n_tests++; if (n_valid !== 9) begin n_fail++; $display("FAIL rr_count got %0d exp 9", n_valid); end
        i = 0;
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front();
            n_tests++; if (o !== e) begin n_fail++; $display("FAIL rr_addr[%0d] got %0d exp %0d", i, o, e); end
            i++;
        end
        n_tests++; if (n_done !== 1) begin n_fail++; $display("FAIL rr_done got %0d exp 1", n_done); end
    endtask

    initial begin
        test_reset();
        test_transpose();
        test_row_major();
        test_stall();
        test_wrap();
        test_restart_clear();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
